// File: rtl/mem_sync_param.sv
// mem_sync_param: parametrised synchronous single-port RAM.
//
// After reset a hardware sweep writes zero to every word. While the sweep runs,
// ready is low and read/write requests are ignored. When the sweep is done the
// block accepts one access per cycle. A read returns its data RD_LAT edges
// after the edge that samples it, together with a one-cycle rd_valid pulse.
// An illegal access is one that asserts read and write together, or that uses
// an address at or above DEPTH. Such an access is dropped, raises a one-cycle
// err pulse and increments the saturating err_cnt.
//
// Optional feature macro: MEM_SYNC_PARITY_EN
//   When defined, every word stores an even-parity bit. The sweep writes a
//   parity bit of 0. The parity_flip input inverts the stored parity bit on a
//   write. A parity mismatch on read data raises parity_err together with
//   rd_valid and increments err_cnt.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   read, write  access requests, sampled on posedge clk
//   addr         word address (ADDR_W bits)
//   data_in      write data (DATA_W bits)
//   ready        high once the clear sweep has finished
//   data_out     read data; holds its value between reads
//   rd_valid     one-cycle pulse when data_out carries new read data
//   err          one-cycle pulse on an illegal access
//   err_cnt      saturating count of illegal accesses (and parity errors)
//   parity_flip  (MEM_SYNC_PARITY_EN only) inverts the stored parity on write
//   parity_err   (MEM_SYNC_PARITY_EN only) parity mismatch pulse with rd_valid
module mem_sync_param #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 32,
    parameter int RD_LAT   = 1,
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                read,
    input  logic                write,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   data_in,
`ifdef MEM_SYNC_PARITY_EN
    input  logic                parity_flip,
    output logic                parity_err,
`endif
    output logic                ready,
    output logic [DATA_W-1:0]   data_out,
    output logic                rd_valid,
    output logic                err,
    output logic [ERRCNT_W-1:0] err_cnt
);

`ifdef MEM_SYNC_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int WORD_W = DATA_W + PAR_W;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ERRCNT_W:0] ERR_MAX = {1'b0, {ERRCNT_W{1'b1}}};

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

`ifdef MEM_SYNC_PARITY_EN
    // The stored bit makes the total number of ones in the word even.
    function automatic logic even_par(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction
`endif

    state_t              state_r, state_s;
    logic [ADDR_W-1:0]   ptr_r, ptr_s;
    logic                ready_r, ready_s;
    logic [WORD_W-1:0]   mem_r [DEPTH];
    logic                mem_we_s;
    logic [ADDR_W-1:0]   mem_waddr_s;
    logic [WORD_W-1:0]   mem_wdata_s;
    logic                rd_req_s;
    logic                ill_s;
    logic                in_range_s;
    logic [ADDR_W-1:0]   rd_idx_s;
    logic [RD_LAT-1:0]   pipe_vld_r;
    logic [WORD_W-1:0]   pipe_data_r [RD_LAT];
    logic [DATA_W-1:0]   data_out_r;
    logic                rd_valid_r;
    logic                err_r;
    logic [ERRCNT_W-1:0] err_cnt_r;
    logic                par_mis_s;
    logic [1:0]          inc_s;
    logic [ERRCNT_W:0]   cnt_sum_s;
`ifdef MEM_SYNC_PARITY_EN
    logic                parity_err_r;
`endif

    // Address range check and a read index that is always inside the array.
    always_comb begin
        in_range_s = ({1'b0, addr} < DEPTH_C);
        if (in_range_s) begin
            rd_idx_s = addr;
        end else begin
            rd_idx_s = {ADDR_W{1'b0}};
        end
    end

    // FSM state, sweep pointer and ready register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_CLEAR;
            ptr_r   <= {ADDR_W{1'b0}};
            ready_r <= 1'b0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            ready_r <= ready_s;
        end
    end

    // Next state, sweep writes and access decode.
    always_comb begin
        state_s     = state_r;
        ptr_s       = ptr_r;
        ready_s     = ready_r;
        mem_we_s    = 1'b0;
        mem_waddr_s = ptr_r;
        mem_wdata_s = {WORD_W{1'b0}};
        rd_req_s    = 1'b0;
        ill_s       = 1'b0;
        case (state_r)
            ST_CLEAR: begin
                mem_we_s    = 1'b1;
                mem_waddr_s = ptr_r;
                if (ptr_r == LAST_PTR) begin
                    state_s = ST_RUN;
                    ready_s = 1'b1;
                    ptr_s   = {ADDR_W{1'b0}};
                end else begin
                    ptr_s = ptr_r + ADDR_W'(1);
                end
            end
            ST_RUN: begin
                ready_s = 1'b1;
                if (read && write) begin
                    ill_s = 1'b1;
                end else if ((read || write) && !in_range_s) begin
                    ill_s = 1'b1;
                end else if (write) begin
                    mem_we_s    = 1'b1;
                    mem_waddr_s = addr;
`ifdef MEM_SYNC_PARITY_EN
                    mem_wdata_s = {even_par(data_in) ^ parity_flip, data_in};
`else
                    mem_wdata_s = data_in;
`endif
                end else if (read) begin
                    rd_req_s = 1'b1;
                end else begin
                    rd_req_s = 1'b0;
                end
            end
            default: begin
                state_s = ST_CLEAR;
                ptr_s   = {ADDR_W{1'b0}};
                ready_s = 1'b0;
            end
        endcase
    end

    // Memory array; its contents are cleared only by the sweep.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Read pipeline: stage 0 samples the array; later stages add latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld_r <= {RD_LAT{1'b0}};
            for (int k = 0; k < RD_LAT; k++) begin
                pipe_data_r[k] <= {WORD_W{1'b0}};
            end
        end else begin
            pipe_vld_r[0] <= rd_req_s;
            if (rd_req_s) begin
                pipe_data_r[0] <= mem_r[rd_idx_s];
            end
            for (int k = 1; k < RD_LAT; k++) begin
                pipe_vld_r[k]  <= pipe_vld_r[k-1];
                pipe_data_r[k] <= pipe_data_r[k-1];
            end
        end
    end

    // Parity check on the word that is about to reach data_out.
    always_comb begin
`ifdef MEM_SYNC_PARITY_EN
        par_mis_s = pipe_vld_r[RD_LAT-1] && (^pipe_data_r[RD_LAT-1] != 1'b0);
`else
        par_mis_s = 1'b0;
`endif
        inc_s     = {1'b0, ill_s} + {1'b0, par_mis_s};
        cnt_sum_s = {1'b0, err_cnt_r} + (ERRCNT_W + 1)'(inc_s);
    end

    // Output registers: read data, strobes and the saturating error count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_r   <= {DATA_W{1'b0}};
            rd_valid_r   <= 1'b0;
            err_r        <= 1'b0;
            err_cnt_r    <= {ERRCNT_W{1'b0}};
`ifdef MEM_SYNC_PARITY_EN
            parity_err_r <= 1'b0;
`endif
        end else begin
            rd_valid_r <= pipe_vld_r[RD_LAT-1];
            if (pipe_vld_r[RD_LAT-1]) begin
                data_out_r <= pipe_data_r[RD_LAT-1][DATA_W-1:0];
            end
            err_r <= ill_s;
            if (cnt_sum_s > ERR_MAX) begin
                err_cnt_r <= ERR_MAX[ERRCNT_W-1:0];
            end else begin
                err_cnt_r <= cnt_sum_s[ERRCNT_W-1:0];
            end
`ifdef MEM_SYNC_PARITY_EN
            parity_err_r <= par_mis_s;
`endif
        end
    end

    assign ready    = ready_r;
    assign data_out = data_out_r;
    assign rd_valid = rd_valid_r;
    assign err      = err_r;
    assign err_cnt  = err_cnt_r;
`ifdef MEM_SYNC_PARITY_EN
    assign parity_err = parity_err_r;
`endif

endmodule

// File: tb/tb_mem_sync_param.sv
// Testbench for mem_sync_param. Two instances share the same stimulus:
//   A: DEPTH=32, RD_LAT=1 (every 5-bit address is legal)
//   B: DEPTH=20, RD_LAT=2 (addresses 20..31 are illegal)
// A reference model predicts every read result, err pulse and err_cnt value.
// Expected reads and errors are queued when the stimulus is driven. Monitors
// pop and compare them when the DUT outputs appear.
module tb_mem_sync_param;

    localparam int DEPTH_A = 32;
    localparam int LAT_A   = 1;
    localparam int DEPTH_B = 20;
    localparam int LAT_B   = 2;
`ifdef MEM_SYNC_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    typedef struct {
        logic [7:0] d;
        logic       pe;
        int         due;
    } rd_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       read = 1'b0;
    logic       write = 1'b0;
    logic [4:0] addr = 5'd0;
    logic [7:0] data_in = 8'd0;
    logic       flip = 1'b0;

    logic       ready_a, rd_valid_a, err_a;
    logic [7:0] data_out_a, err_cnt_a;
    logic       ready_b, rd_valid_b, err_b;
    logic [7:0] data_out_b, err_cnt_b;
`ifdef MEM_SYNC_PARITY_EN
    logic       perr_a, perr_b;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;

    rd_t qa[$];
    rd_t qb[$];
    int  qea[$];
    int  qeb[$];
    logic [7:0] mem_m [2][32];
    bit         flp_m [2][32];
    int         clr_left [2];
    int         cnt_m [2];

    mem_sync_param #(.DATA_W(8), .ADDR_W(5), .DEPTH(DEPTH_A), .RD_LAT(LAT_A), .ERRCNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .read(read), .write(write), .addr(addr), .data_in(data_in),
`ifdef MEM_SYNC_PARITY_EN
        .parity_flip(flip), .parity_err(perr_a),
`endif
        .ready(ready_a), .data_out(data_out_a), .rd_valid(rd_valid_a), .err(err_a), .err_cnt(err_cnt_a)
    );

    mem_sync_param #(.DATA_W(8), .ADDR_W(5), .DEPTH(DEPTH_B), .RD_LAT(LAT_B), .ERRCNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .read(read), .write(write), .addr(addr), .data_in(data_in),
`ifdef MEM_SYNC_PARITY_EN
        .parity_flip(flip), .parity_err(perr_b),
`endif
        .ready(ready_b), .data_out(data_out_b), .rd_valid(rd_valid_b), .err(err_b), .err_cnt(err_cnt_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void bump(input int i);
        if (cnt_m[i] < 255) cnt_m[i] = cnt_m[i] + 1;
    endfunction

    // Drive one edge of stimulus and advance the model by the same edge.
    task automatic cycle(input logic rd, input logic wr, input int a, input logic [7:0] d, input logic f);
        rd_t e;
        read = rd;
        write = wr;
        addr = a[4:0];
        data_in = d;
        flip = f;
        for (int i = 0; i < 2; i++) begin
            int dep;
            int lat;
            dep = (i == 0) ? DEPTH_A : DEPTH_B;
            lat = (i == 0) ? LAT_A : LAT_B;
            if (clr_left[i] > 0) begin
                clr_left[i] = clr_left[i] - 1;
            end else if (rd || wr) begin
                if ((rd && wr) || a >= dep) begin
                    if (i == 0) qea.push_back(cyc + 1);
                    else qeb.push_back(cyc + 1);
                    bump(i);
                end else if (wr) begin
                    mem_m[i][a] = d;
                    flp_m[i][a] = f;
                end else begin
                    e.d = mem_m[i][a];
                    e.pe = PAR_ON && flp_m[i][a];
                    e.due = cyc + 1 + lat;
                    if (e.pe) bump(i);
                    if (i == 0) qa.push_back(e);
                    else qb.push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 0, 8'd0, 1'b0);
    endtask

    // Assert reset, discard in-flight expectations and restart the model.
    task automatic do_reset();
        rst = 1'b1;
        read = 1'b0;
        write = 1'b0;
        qa.delete();
        qb.delete();
        qea.delete();
        qeb.delete();
        for (int i = 0; i < 2; i++) begin
            clr_left[i] = (i == 0) ? DEPTH_A : DEPTH_B;
            cnt_m[i] = 0;
            for (int j = 0; j < 32; j++) begin
                mem_m[i][j] = 8'd0;
                flp_m[i][j] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Read scoreboard and err checks for instance A.
    always @(posedge clk) begin
        rd_t e;
        #2;
        if (!rst) begin
            if (rd_valid_a) begin
                total++;
                if (qa.size() == 0) begin
                    bad++;
                    $display("FAIL a_spurious_rd_valid cyc=%0d data_out=%h", cyc, data_out_a);
                end else begin
                    e = qa.pop_front();
                    if (data_out_a !== e.d || cyc != e.due) begin
                        bad++;
                        $display("FAIL a_read data=%h want=%h cyc=%0d want_cyc=%0d", data_out_a, e.d, cyc, e.due);
                    end
`ifdef MEM_SYNC_PARITY_EN
                    if (perr_a !== e.pe) begin
                        bad++;
                        $display("FAIL a_parity_err got=%b want=%b", perr_a, e.pe);
                    end
`endif
                end
            end else if (qa.size() > 0 && qa[0].due == cyc) begin
                total++;
                bad++;
                $display("FAIL a_missing_rd_valid cyc=%0d got=0 want=1", cyc);
                void'(qa.pop_front());
            end
            if (err_a) begin
                total++;
                if (qea.size() == 0 || qea[0] != cyc) begin
                    bad++;
                    $display("FAIL a_spurious_err cyc=%0d got=1 want=0", cyc);
                end else begin
                    void'(qea.pop_front());
                end
            end else if (qea.size() > 0 && qea[0] == cyc) begin
                total++;
                bad++;
                $display("FAIL a_missing_err cyc=%0d got=0 want=1", cyc);
                void'(qea.pop_front());
            end
        end
    end

    // Read scoreboard and err checks for instance B.
    always @(posedge clk) begin
        rd_t e;
        #2;
        if (!rst) begin
            if (rd_valid_b) begin
                total++;
                if (qb.size() == 0) begin
                    bad++;
                    $display("FAIL b_spurious_rd_valid cyc=%0d data_out=%h", cyc, data_out_b);
                end else begin
                    e = qb.pop_front();
                    if (data_out_b !== e.d || cyc != e.due) begin
                        bad++;
                        $display("FAIL b_read data=%h want=%h cyc=%0d want_cyc=%0d", data_out_b, e.d, cyc, e.due);
                    end
`ifdef MEM_SYNC_PARITY_EN
                    if (perr_b !== e.pe) begin
                        bad++;
                        $display("FAIL b_parity_err got=%b want=%b", perr_b, e.pe);
                    end
`endif
                end
            end else if (qb.size() > 0 && qb[0].due == cyc) begin
                total++;
                bad++;
                $display("FAIL b_missing_rd_valid cyc=%0d got=0 want=1", cyc);
                void'(qb.pop_front());
            end
            if (err_b) begin
                total++;
                if (qeb.size() == 0 || qeb[0] != cyc) begin
                    bad++;
                    $display("FAIL b_spurious_err cyc=%0d got=1 want=0", cyc);
                end else begin
                    void'(qeb.pop_front());
                end
            end else if (qeb.size() > 0 && qeb[0] == cyc) begin
                total++;
                bad++;
                $display("FAIL b_missing_err cyc=%0d got=0 want=1", cyc);
                void'(qeb.pop_front());
            end
        end
    end

    task automatic test_reset();
        do_reset();
        total++;
        if (ready_a !== 1'b0 || ready_b !== 1'b0 || rd_valid_a !== 1'b0 || rd_valid_b !== 1'b0 ||
            err_a !== 1'b0 || err_b !== 1'b0 || data_out_a !== 8'd0 || data_out_b !== 8'd0 ||
            err_cnt_a !== 8'd0 || err_cnt_b !== 8'd0) begin
            bad++;
            $display("FAIL reset_values ready=%b/%b rv=%b/%b err=%b/%b dout=%h/%h cnt=%h/%h want all 0",
                     ready_a, ready_b, rd_valid_a, rd_valid_b, err_a, err_b,
                     data_out_a, data_out_b, err_cnt_a, err_cnt_b);
        end
        rst = 1'b0;
        // Partial sweep with requests that must be ignored, then restart.
        for (int k = 0; k < 10; k++) cycle(1'b1, 1'b0, k, 8'd0, 1'b0);
        do_reset();
        rst = 1'b0;
        for (int k = 1; k <= DEPTH_A + 1; k++) begin
            cycle(1'b1, 1'b0, k % 32, 8'd0, 1'b0);
            total++;
            if (ready_a !== (clr_left[0] == 0) || ready_b !== (clr_left[1] == 0)) begin
                bad++;
                $display("FAIL ready_sweep edge=%0d got=%b/%b want=%b/%b", k, ready_a, ready_b,
                         clr_left[0] == 0, clr_left[1] == 0);
            end
        end
        idle(4);
    endtask

    task automatic test_clear_readback();
        for (int a = 0; a < 32; a++) cycle(1'b1, 1'b0, a, 8'd0, 1'b0);
        idle(4);
        total++;
        if (err_cnt_a !== 8'(cnt_m[0]) || err_cnt_b !== 8'(cnt_m[1])) begin
            bad++;
            $display("FAIL clear_readback_errcnt got=%0d/%0d want=%0d/%0d", err_cnt_a, err_cnt_b, cnt_m[0], cnt_m[1]);
        end
    endtask

    task automatic test_write_read();
        cycle(1'b0, 1'b1, 3, 8'hA5, 1'b0);
        cycle(1'b1, 1'b0, 3, 8'h00, 1'b0);
        idle(4);
    endtask

    task automatic test_rw_conflict();
        cycle(1'b0, 1'b1, 7, 8'h3C, 1'b0);
        cycle(1'b1, 1'b1, 7, 8'hFF, 1'b0);
        cycle(1'b1, 1'b0, 7, 8'h00, 1'b0);
        idle(4);
        total++;
        if (err_cnt_a !== 8'(cnt_m[0]) || err_cnt_b !== 8'(cnt_m[1])) begin
            bad++;
            $display("FAIL rw_conflict_errcnt got=%0d/%0d want=%0d/%0d", err_cnt_a, err_cnt_b, cnt_m[0], cnt_m[1]);
        end
    endtask

    task automatic test_out_of_range();
        cycle(1'b0, 1'b1, 25, 8'h5A, 1'b0);
        cycle(1'b1, 1'b0, 25, 8'h00, 1'b0);
        cycle(1'b0, 1'b1, 19, 8'h19, 1'b0);
        cycle(1'b0, 1'b1, 20, 8'h20, 1'b0);
        cycle(1'b1, 1'b0, 19, 8'h00, 1'b0);
        cycle(1'b1, 1'b0, 20, 8'h00, 1'b0);
        cycle(1'b0, 1'b1, 31, 8'h77, 1'b0);
        cycle(1'b1, 1'b0, 31, 8'h00, 1'b0);
        idle(4);
        total++;
        if (err_cnt_a !== 8'(cnt_m[0]) || err_cnt_b !== 8'(cnt_m[1])) begin
            bad++;
            $display("FAIL out_of_range_errcnt got=%0d/%0d want=%0d/%0d", err_cnt_a, err_cnt_b, cnt_m[0], cnt_m[1]);
        end
    endtask

    task automatic test_back_to_back();
        for (int a = 0; a < 3; a++) cycle(1'b0, 1'b1, a, 8'(a + 1), 1'b0);
        for (int a = 0; a < 3; a++) cycle(1'b1, 1'b0, a, 8'h00, 1'b0);
        idle(5);
        total++;
        if (data_out_a !== 8'd3 || data_out_b !== 8'd3) begin
            bad++;
            $display("FAIL data_out_hold got=%h/%h want=03/03", data_out_a, data_out_b);
        end
        // Reset while reads are still in flight.
        for (int a = 0; a < 3; a++) cycle(1'b1, 1'b0, a, 8'h00, 1'b0);
        do_reset();
        total++;
        if (data_out_a !== 8'd0 || data_out_b !== 8'd0 || rd_valid_a !== 1'b0 || rd_valid_b !== 1'b0) begin
            bad++;
            $display("FAIL midpipe_reset dout=%h/%h rv=%b/%b want 0", data_out_a, data_out_b, rd_valid_a, rd_valid_b);
        end
        rst = 1'b0;
        idle(1);
        total++;
        if (ready_a !== 1'b0 || ready_b !== 1'b0) begin
            bad++;
            $display("FAIL sweep_restart ready=%b/%b want=0/0", ready_a, ready_b);
        end
        idle(DEPTH_A);
        total++;
        if (ready_a !== 1'b1 || ready_b !== 1'b1) begin
            bad++;
            $display("FAIL sweep_done ready=%b/%b want=1/1", ready_a, ready_b);
        end
        for (int a = 0; a < 3; a++) cycle(1'b1, 1'b0, a, 8'h00, 1'b0);
        idle(4);
    endtask

    task automatic test_parity();
        cycle(1'b0, 1'b1, 5, 8'h01, 1'b1);
        cycle(1'b1, 1'b0, 5, 8'h00, 1'b0);
        cycle(1'b0, 1'b1, 6, 8'h03, 1'b0);
        cycle(1'b1, 1'b0, 6, 8'h00, 1'b0);
        idle(4);
        total++;
        if (err_cnt_a !== 8'(cnt_m[0]) || err_cnt_b !== 8'(cnt_m[1])) begin
            bad++;
            $display("FAIL parity_errcnt got=%0d/%0d want=%0d/%0d", err_cnt_a, err_cnt_b, cnt_m[0], cnt_m[1]);
        end
    endtask

    task automatic test_err_saturate();
        for (int k = 0; k < 300; k++) cycle(1'b1, 1'b1, k % 32, 8'h00, 1'b0);
        idle(3);
        total++;
        if (err_cnt_a !== 8'(cnt_m[0]) || err_cnt_b !== 8'(cnt_m[1]) || err_cnt_a !== 8'hFF) begin
            bad++;
            $display("FAIL err_saturate got=%0d/%0d want=%0d/%0d", err_cnt_a, err_cnt_b, cnt_m[0], cnt_m[1]);
        end
    endtask

    initial begin
        test_reset();
        test_clear_readback();
        test_write_read();
        test_rw_conflict();
        test_out_of_range();
        test_back_to_back();
        test_parity();
        test_err_saturate();
        total++;
        if (qa.size() != 0 || qb.size() != 0 || qea.size() != 0 || qeb.size() != 0) begin
            bad++;
            $display("FAIL leftover_expectations got=%0d/%0d/%0d/%0d want=0", qa.size(), qb.size(), qea.size(), qeb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
